// File: rtl/rst_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rst_sequencer_if : reset sources in, staged resets / status out           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rst_sequencer_if #(
  parameter int p_STAGES = 3
);
  logic                i_ext_rst_n;
  logic                i_pll_locked;
  logic                i_soft_rst;
  logic [p_STAGES-1:0] o_rst;
  logic                o_ready;
  logic [1:0]          o_cause;

  modport master (
    output i_ext_rst_n, i_pll_locked, i_soft_rst,
    input  o_rst, o_ready, o_cause
  );

  modport slave (
    input  i_ext_rst_n, i_pll_locked, i_soft_rst,
    output o_rst, o_ready, o_cause
  );
endinterface
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rst_sequencer : merges POR/button/PLL/software resets, releases stages   |
// | in order with fixed spacing. Rev 1.0                                     |
// +--------------------------------------------------------------------------+
module rst_sequencer #(
  parameter int p_STAGES = 3,
  parameter int p_DLY    = 16,
  parameter int p_DEB    = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rst_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(p_DLY);
  localparam int IDX_W = (p_STAGES > 1) ? $clog2(p_STAGES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_DLY - 1);
  localparam logic [7:0]       DEB_LAST = 8'(p_DEB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((p_STAGES > 1) ? (p_STAGES - 2) : 0);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_PLL = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [p_STAGES-1:0] rst_q, rst_d;
  logic                ready_q, ready_d;
  logic [1:0]          cause_q, cause_d;

  logic                ext_meta_q, ext_meta_d;
  logic                ext_s_q, ext_s_d;
  logic                lock_meta_q, lock_meta_d;
  logic                lock_s_q, lock_s_d;
  logic [7:0]          deb_cnt_q, deb_cnt_d;

  logic                ext_req;
  logic                pll_loss;
  logic                req;

  // deb_cnt_q saturates at p_DEB-1, so the current low sample completes the run
  assign ext_req  = !ext_s_q && (deb_cnt_q == DEB_LAST);
  assign pll_loss = !lock_s_q && (state_q != S_HOLD);
  assign req      = ext_req || bus.i_soft_rst || pll_loss;

  always_comb begin
    ext_meta_d  = bus.i_ext_rst_n;
    ext_s_d     = ext_meta_q;
    lock_meta_d = bus.i_pll_locked;
    lock_s_d    = lock_meta_q;

    if (ext_s_q) begin
      deb_cnt_d = 8'd0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d = deb_cnt_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 8'd1;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;

    if (req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      if (pll_loss) begin
        cause_d = CAUSE_PLL;
      end else if (ext_req) begin
        cause_d = CAUSE_BTN;
      end else begin
        cause_d = CAUSE_SW;
      end
    end else begin
      case (state_q)
        S_HOLD: begin
          rst_d   = '1;
          ready_d = 1'b0;
          if (!lock_s_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = '0;
            if (p_STAGES == 1) begin
              rst_d   = '0;
              ready_d = 1'b1;
              state_d = S_RUN;
            end else begin
              rst_d[0] = 1'b0;
              state_d  = S_REL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_REL: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              rst_d   = '0;
              ready_d = 1'b1;
              state_d = S_RUN;
            end else begin
              for (int k = 0; k < p_STAGES; k++) begin
                if (k == int'(idx_q) + 1) begin
                  rst_d[k] = 1'b0;
                end
              end
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end

        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // Synchronizers preset to the inactive level: button released, PLL unlocked
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ext_meta_q  <= 1'b1;
      ext_s_q     <= 1'b1;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      deb_cnt_q   <= 8'd0;
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else begin
      ext_meta_q  <= ext_meta_d;
      ext_s_q     <= ext_s_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      cause_q     <= cause_d;
    end
  end

  assign bus.o_rst   = rst_q;
  assign bus.o_ready = ready_q;
  assign bus.o_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rst_sequencer : directed scenarios, expected output events queued and  |
// | matched by an independent monitor. Rev 1.0                               |
// +--------------------------------------------------------------------------+
module tb_rst_sequencer;

  localparam int P_STAGES = 3;
  localparam int P_DLY    = 4;
  localparam int P_DEB    = 3;
  localparam int W        = P_STAGES + 3;

  typedef struct {
    logic [W-1:0] val;
    int           lo;
    int           hi;
    string        tag;
  } exp_t;

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  int           cyc        = 0;
  int           n_cmp      = 0;
  int           n_bad      = 0;
  int           force_req  = 0;
  int           force_done = 0;
  bit           fin_req    = 1'b0;
  bit           fin_done   = 1'b0;
  exp_t         sb[$];
  logic [W-1:0] prev       = {{P_STAGES{1'b1}}, 3'b000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rst_sequencer_if #(.p_STAGES(P_STAGES)) bus ();

  rst_sequencer #(
    .p_STAGES (P_STAGES),
    .p_DLY    (P_DLY),
    .p_DEB    (P_DEB)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [P_STAGES-1:0] r, input logic rdy, input logic [1:0] c,
                      input int lo, input int hi, input string tag);
    exp_t e;
    e.val = {r, rdy, c};
    e.lo  = lo;
    e.hi  = hi;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Release pattern: stage 0 at base, stage 1 at base+4, stage 2 + ready at base+8
  task automatic push_rel(input int base, input logic [1:0] c, input string tag);
    push(3'b110, 1'b0, c, base,     base,     {tag, "_rel0"});
    push(3'b100, 1'b0, c, base + 4, base + 4, {tag, "_rel1"});
    push(3'b000, 1'b1, c, base + 8, base + 8, {tag, "_ready"});
  endtask

  // Output events are matched in order against the queue; forced checks compare without a change
  always @(negedge clk) begin : monitor
    logic [W-1:0] cur;
    exp_t         e;
    cur = {bus.o_rst, bus.o_ready, bus.o_cause};
    if (force_req != force_done || cur !== prev) begin
      force_done = force_req;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change @edge %0d: got %b (was %b), required no change", cyc, cur, prev);
      end else begin
        e = sb.pop_front();
        if (cur !== e.val || cyc < e.lo || cyc > e.hi) begin
          n_bad++;
          $display("FAIL %s @edge %0d: got %b, required %b at edge %0d..%0d",
                   e.tag, cyc, cur, e.val, e.lo, e.hi);
        end
      end
    end
    if (fin_req && !fin_done) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL drain: %0d expected events not seen, required 0", sb.size());
      end
      fin_done = 1'b1;
    end
    prev = cur;
  end

  initial begin : stim
    int b;
    bus.i_ext_rst_n  = 1'b1;
    bus.i_pll_locked = 1'b1;
    bus.i_soft_rst   = 1'b0;

    tick(2);
    push(3'b111, 1'b0, 2'd0, cyc, cyc + 1, "reset_state");
    force_req = force_req + 1;
    tick(2);

    // POR release: the lock synchronizer starts unlocked, so the 4/8/12 spacing begins 2 edges late
    rst = 1'b0;
    b   = cyc;
    push_rel(b + 6, 2'd0, "por");
    tick(16);

    // 2-cycle button glitch must be filtered
    bus.i_ext_rst_n = 1'b0;
    tick(2);
    bus.i_ext_rst_n = 1'b1;
    tick(8);

    // 10-cycle press; release starts p_DLY edges after ext_s returns high
    b = cyc;
    bus.i_ext_rst_n = 1'b0;
    push(3'b111, 1'b0, 2'd1, b + 2, b + 6, "btn_assert");
    push_rel(b + 16, 2'd1, "btn");
    tick(10);
    bus.i_ext_rst_n = 1'b1;
    tick(16);

    // Software reset in run
    b = cyc;
    bus.i_soft_rst = 1'b1;
    push(3'b111, 1'b0, 2'd2, b + 1, b + 1, "soft_assert");
    push_rel(b + 5, 2'd2, "soft");
    tick(1);
    bus.i_soft_rst = 1'b0;
    tick(15);

    // PLL loss while o_rst = 110
    b = cyc;
    bus.i_soft_rst = 1'b1;
    push(3'b111, 1'b0, 2'd2, b + 1, b + 1, "soft_pre_pll");
    push(3'b110, 1'b0, 2'd2, b + 5, b + 5, "rel0_pre_pll");
    push(3'b111, 1'b0, 2'd3, b + 7, b + 9, "pll_assert");
    push_rel(b + 21, 2'd3, "pll");
    tick(1);
    bus.i_soft_rst = 1'b0;
    tick(5);
    bus.i_pll_locked = 1'b0;
    tick(9);
    bus.i_pll_locked = 1'b1;
    tick(16);

    // Button request and soft pulse on the same edge
    b = cyc;
    bus.i_ext_rst_n = 1'b0;
    push(3'b111, 1'b0, 2'd1, b + 5, b + 5, "soft_btn_cause");
    push_rel(b + 9, 2'd1, "soft_btn");
    tick(3);
    bus.i_ext_rst_n = 1'b1;
    tick(1);
    bus.i_soft_rst = 1'b1;
    tick(1);
    bus.i_soft_rst = 1'b0;
    tick(14);

    // Button, soft and PLL loss all seen on the same edge
    b = cyc;
    bus.i_ext_rst_n = 1'b0;
    push(3'b111, 1'b0, 2'd3, b + 5, b + 5, "all_src_cause");
    push_rel(b + 9, 2'd3, "all_src");
    tick(2);
    bus.i_pll_locked = 1'b0;
    tick(1);
    bus.i_ext_rst_n  = 1'b1;
    bus.i_pll_locked = 1'b1;
    tick(1);
    bus.i_soft_rst = 1'b1;
    tick(1);
    bus.i_soft_rst = 1'b0;
    tick(14);

    // Reach run with cause 2, then pulse i_rst
    b = cyc;
    bus.i_soft_rst = 1'b1;
    push(3'b111, 1'b0, 2'd2, b + 1, b + 1, "soft_pre_rst");
    push_rel(b + 5, 2'd2, "soft2");
    tick(1);
    bus.i_soft_rst = 1'b0;
    tick(15);

    b   = cyc;
    rst = 1'b1;
    push(3'b111, 1'b0, 2'd0, b + 1, b + 1, "rst_midrun");
    push_rel(b + 7, 2'd0, "rst_restart");
    tick(1);
    rst = 1'b0;
    tick(17);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) begin
      tick(1);
    end
    if (!fin_done) begin
      $display("FAIL drain_timeout: monitor did not respond, required response within 10 cycles");
      $fatal(1, "monitor stalled");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
